// File: rtl/packet_src_arbiter.sv
// Round-robin scheduler sharing one 3-byte packet parser among NUM_SRC byte-stream sources.
// Collects a whole packet from the granted source, replays it back-to-back, then tags the done cycle.
module packet_src_arbiter #(
  parameter  int unsigned NUM_SRC  = 4,
  parameter  int unsigned SYNC_BIT = 3,
  parameter  int unsigned TIMEOUT  = 16,
  parameter  int unsigned CNT_W    = 8,
  localparam int unsigned ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  output logic [NUM_SRC-1:0]     src_ready,
  output logic [7:0]             par_in,
  output logic [ID_W-1:0]        pkt_src,
  output logic                   pkt_src_valid,
  output logic                   busy,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_BURST0,
    S_BURST1,
    S_BURST2,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [1:0]           idx_q, idx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [2:0][7:0]      pbuf_q, pbuf_d;
  logic [CNT_W-1:0]     drop_q, drop_d;

  logic                 drop_inc;
  logic                 any_req;
  logic [ID_W-1:0]      pick;
  logic [ID_W-1:0]      pick_next;
  int unsigned          cand;
  logic [7:0]           cur_byte;
  logic                 xfer;

  // Scan offsets from the highest down so the nearest valid source at or after ptr wins.
  always_comb begin
    pick    = ptr_q;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = 32'(ptr_q) + (NUM_SRC - 1 - k);
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (src_valid[cand[ID_W-1:0]]) begin
        pick    = ID_W'(cand);
        any_req = 1'b1;
      end
    end
  end

  assign pick_next = (pick == ID_W'(NUM_SRC - 1)) ? '0 : pick + 1'b1;

  always_comb begin
    cur_byte = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (grant_q == ID_W'(k)) cur_byte = src_data[8*k +: 8];
    end
  end

  assign xfer = |(src_valid & src_ready);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    pbuf_d   = pbuf_q;
    drop_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          ptr_d   = pick_next;
          idx_d   = '0;
          tmo_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          tmo_d = '0;
          if ((idx_q == 2'd0) && !cur_byte[SYNC_BIT]) begin
            drop_inc = 1'b1;
            state_d  = S_IDLE;
          end else begin
            pbuf_d[idx_q] = cur_byte;
            idx_d         = idx_q + 2'd1;
            if (idx_q == 2'd2) state_d = S_BURST0;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          drop_inc = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_BURST0: state_d = S_BURST1;
      S_BURST1: state_d = S_BURST2;
      S_BURST2: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign drop_d = (drop_inc && !(&drop_q)) ? drop_q + 1'b1 : drop_q;

  // Every output is a pure decode of registered state, so reset clears them immediately.
  always_comb begin
    src_ready     = '0;
    par_in        = 8'h00;
    pkt_src       = '0;
    pkt_src_valid = 1'b0;
    unique case (state_q)
      S_COLLECT: src_ready = NUM_SRC'(1) << grant_q;
      S_BURST0:  par_in    = pbuf_q[0];
      S_BURST1:  par_in    = pbuf_q[1];
      S_BURST2:  par_in    = pbuf_q[2];
      S_DONE: begin
        pkt_src       = grant_q;
        pkt_src_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      pbuf_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      pbuf_q  <= pbuf_d;
      drop_q  <= drop_d;
    end
  end

endmodule
